// File: rtl/uart_core.sv
// Full-duplex UART: transmitter and receiver FSMs sharing one baud configuration.
// Define UART_CORE_PARITY_EN to add a parity bit whose sense is set by PARITY_ODD.
module uart_core #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD_COUNT = CLK_FREQ / BAUD_RATE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] data_in,
    input  logic            tx_en,
    input  logic            loopback,
    input  logic            rx,
    output logic            tx,
    output logic            tx_busy,
    output logic [SIZE-1:0] data_out,
    output logic            rx_done,
    output logic            frame_err,
    output logic            parity_err
);
    localparam int unsigned   CW        = $clog2(BAUD_COUNT);
    localparam int unsigned   BW        = $clog2(SIZE);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_COUNT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(SIZE - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (SIZE < 5 || SIZE > 9 || BAUD_COUNT < 4 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD > 1) begin : g_cfg_check
        $error("uart_core: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        TxIdle, TxStart, TxData,
`ifdef UART_CORE_PARITY_EN
        TxParity,
`endif
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData,
`ifdef UART_CORE_PARITY_EN
        RxParity,
`endif
        RxStop
    } rx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]   tx_bit_q, tx_bit_d;
    logic [SIZE-1:0] tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d, tx_busy_q, tx_busy_d, tx_bit_end;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]   rx_bit_q, rx_bit_d;
    logic [SIZE-1:0] rx_shift_q, rx_shift_d, data_out_q, data_out_d;
    logic            rx_s1_q, rx_s2_q, rx_h_q, rx_fall, rx_sample;
    logic            rx_done_q, rx_done_d, frame_err_q, frame_err_d;

`ifdef UART_CORE_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic tx_par_q, tx_par_d, rx_par_q, rx_par_d, parity_err_q, parity_err_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
`ifdef UART_CORE_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        tx_bit_end = (tx_cnt_q == BAUD_LAST);
        if (tx_state_q != TxIdle) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        unique case (tx_state_q)
            TxIdle: if (tx_en) begin
                tx_shift_d = data_in;
`ifdef UART_CORE_PARITY_EN
                tx_par_d   = (^data_in) ^ PAR_ODD;
`endif
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = 1'b0;
                tx_busy_d  = 1'b1;
                tx_state_d = TxStart;
            end
            TxStart: if (tx_bit_end) begin
                tx_d       = tx_shift_q[0];
                tx_state_d = TxData;
            end
            TxData: if (tx_bit_end) begin
                if (tx_bit_q == DATA_LAST) begin
                    tx_bit_d   = '0;
`ifdef UART_CORE_PARITY_EN
                    tx_d       = tx_par_q;
                    tx_state_d = TxParity;
`else
                    tx_d       = 1'b1;
                    tx_state_d = TxStop;
`endif
                end else begin
                    tx_bit_d   = tx_bit_q + BW'(1);
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end
            end
`ifdef UART_CORE_PARITY_EN
            TxParity: if (tx_bit_end) begin
                tx_d       = 1'b1;
                tx_state_d = TxStop;
            end
`endif
            TxStop: if (tx_bit_end) begin
                if (tx_bit_q == STOP_LAST) begin
                    tx_busy_d  = 1'b0;
                    tx_state_d = TxIdle;
                end else begin
                    tx_bit_d = tx_bit_q + BW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign rx_fall = rx_h_q & ~rx_s2_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        data_out_d  = data_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_CORE_PARITY_EN
        rx_par_d     = rx_par_q;
        parity_err_d = parity_err_q;
`endif
        // Start bit is sampled at its midpoint; every later bit a full period after that.
        rx_sample = (rx_state_q == RxStart) ? (rx_cnt_q == HALF_LAST) : (rx_cnt_q == BAUD_LAST);
        if (rx_state_q != RxIdle) rx_cnt_d = rx_sample ? '0 : rx_cnt_q + CW'(1);
        unique case (rx_state_q)
            RxIdle: if (rx_fall) begin
                rx_cnt_d   = '0;
                rx_state_d = RxStart;
            end
            RxStart: if (rx_sample) begin
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? RxIdle : RxData;
            end
            RxData: if (rx_sample) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[SIZE-1:1]};
                if (rx_bit_q == DATA_LAST) begin
                    rx_bit_d   = '0;
`ifdef UART_CORE_PARITY_EN
                    rx_state_d = RxParity;
`else
                    rx_state_d = RxStop;
`endif
                end else begin
                    rx_bit_d = rx_bit_q + BW'(1);
                end
            end
`ifdef UART_CORE_PARITY_EN
            RxParity: if (rx_sample) begin
                rx_par_d   = rx_s2_q;
                rx_state_d = RxStop;
            end
`endif
            RxStop: if (rx_sample) begin
                data_out_d  = rx_shift_q;
                frame_err_d = ~rx_s2_q;
`ifdef UART_CORE_PARITY_EN
                parity_err_d = ((^rx_shift_q) ^ rx_par_q) != PAR_ODD;
`endif
                rx_done_d   = 1'b1;
                rx_state_d  = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_h_q      <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            data_out_q  <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_CORE_PARITY_EN
            tx_par_q     <= 1'b0;
            rx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            rx_s1_q     <= loopback ? tx_q : rx;
            rx_s2_q     <= rx_s1_q;
            rx_h_q      <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            data_out_q  <= data_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_CORE_PARITY_EN
            tx_par_q     <= tx_par_d;
            rx_par_q     <= rx_par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = tx_busy_q;
    assign data_out  = data_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
`ifdef UART_CORE_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at default parameters (BAUD_COUNT = 8, SIZE = 8).
// Parity cases are compiled in only when UART_CORE_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int BAUD = 8;
`ifdef UART_CORE_PARITY_EN
    localparam int FRAME_N = 11;
`else
    localparam int FRAME_N = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       tx_en, loopback, rx;
    logic       tx, tx_busy, rx_done, frame_err, parity_err;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;

    int         rx_cnt = 0;
    logic [7:0] rx_data_q[$];
    logic       rx_last_fe, rx_last_pe;

    always #5 clk = ~clk;

    uart_core dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .tx_en      (tx_en),
        .loopback   (loopback),
        .rx         (rx),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always @(negedge clk) begin
        if (rst && rx_done) begin
            rx_cnt++;
            rx_data_q.push_back(data_out);
            rx_last_fe = frame_err;
            rx_last_pe = parity_err;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame as it appears on the line, LSB first: start, data, [parity], stop.
    function automatic logic [11:0] line_frame(input logic [7:0] d, input logic stop);
`ifdef UART_CORE_PARITY_EN
        return {1'b0, stop, ^d, d, 1'b0};
`else
        return {2'b00, stop, d, 1'b0};
`endif
    endfunction

    task automatic send_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[0];
            bits = bits >> 1;
            repeat (BAUD) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_busy(input logic lvl, input int max, output int n);
        n = 0;
        while (tx_busy !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) check_eq("busy_timeout", 32'(tx_busy), 32'(lvl));
    endtask

    initial begin
        logic [11:0] exp;
        int bad, bad_tx, bad_busy, base, n;

        rst = 1'b0; data_in = '0; tx_en = 1'b0; loopback = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx), 1);
        check_eq("rst_busy", 32'(tx_busy), 0);
        check_eq("rst_data", 32'(data_out), 0);
        check_eq("rst_done", 32'(rx_done), 0);
        check_eq("rst_ferr", 32'(frame_err), 0);
        check_eq("rst_perr", 32'(parity_err), 0);

        rst = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || rx_done !== 1'b0 ||
                frame_err !== 1'b0 || parity_err !== 1'b0) bad++;
        end
        check_eq("idle_quiet", bad, 0);

        // Loopback single frame 0xA5.
        base = rx_cnt;
        loopback = 1'b1; data_in = 8'hA5; tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0; data_in = '0;
        exp = line_frame(8'hA5, 1'b1);
        bad_tx = 0; bad_busy = 0;
        for (int i = 0; i < BAUD * FRAME_N; i++) begin
            if (tx !== exp[0]) bad_tx++;
            if (tx_busy !== 1'b1) bad_busy++;
            if ((i % BAUD) == BAUD - 1) exp = exp >> 1;
            @(negedge clk);
        end
        check_eq("a5_tx_wave", bad_tx, 0);
        check_eq("a5_busy_len", bad_busy, 0);
        check_eq("a5_busy_fall", 32'(tx_busy), 0);
        repeat (5) @(negedge clk);
        check_eq("a5_rx_count", rx_cnt, base + 1);
        if (rx_cnt == base + 1) begin
            check_eq("a5_rx_data", 32'(rx_data_q[base]), 'hA5);
            check_eq("a5_ferr", 32'(rx_last_fe), 0);
            check_eq("a5_perr", 32'(rx_last_pe), 0);
        end

        // Back-to-back frames with tx_en held high.
        base = rx_cnt;
        data_in = 8'h00; tx_en = 1'b1;
        wait_busy(1'b1, 20, n);
        data_in = 8'hFF;
        wait_busy(1'b0, 200, n);
        wait_busy(1'b1, 20, n);
        check_eq("b2b_gap", n, 1);
        tx_en = 1'b0;
        wait_busy(1'b0, 200, n);
        repeat (5) @(negedge clk);
        check_eq("b2b_rx_count", rx_cnt, base + 2);
        if (rx_cnt == base + 2) begin
            check_eq("b2b_rx_first", 32'(rx_data_q[base]), 'h00);
            check_eq("b2b_rx_second", 32'(rx_data_q[base + 1]), 'hFF);
        end

        // External line: bad stop bit, then a good frame.
        loopback = 1'b0;
        repeat (5) @(negedge clk);
        base = rx_cnt;
        send_bits(line_frame(8'h3C, 1'b0), FRAME_N);
        repeat (20) @(negedge clk);
        check_eq("ferr_rx_count", rx_cnt, base + 1);
        check_eq("ferr_data", 32'(data_out), 'h3C);
        check_eq("ferr_flag", 32'(frame_err), 1);
        send_bits(line_frame(8'h55, 1'b1), FRAME_N);
        repeat (10) @(negedge clk);
        check_eq("good_data", 32'(data_out), 'h55);
        check_eq("good_ferr_clr", 32'(frame_err), 0);

        // False start: 3-cycle low glitch.
        base = rx_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("false_start_none", rx_cnt, base);
        send_bits(line_frame(8'h12, 1'b1), FRAME_N);
        repeat (10) @(negedge clk);
        check_eq("after_glitch_count", rx_cnt, base + 1);
        check_eq("after_glitch_data", 32'(data_out), 'h12);

`ifdef UART_CORE_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1.
        send_bits({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, FRAME_N);
        repeat (10) @(negedge clk);
        check_eq("par_bad_data", 32'(data_out), 'h07);
        check_eq("par_bad_flag", 32'(parity_err), 1);
        send_bits({1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, FRAME_N);
        repeat (10) @(negedge clk);
        check_eq("par_good_flag", 32'(parity_err), 0);
`endif

        // Reset in the middle of a transmission.
        data_in = 8'hC3; tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("midtx_busy", 32'(tx_busy), 1);
        #2 rst = 1'b0;
        #1;
        check_eq("midtx_rst_tx", 32'(tx), 1);
        check_eq("midtx_rst_busy", 32'(tx_busy), 0);
        check_eq("midtx_rst_data", 32'(data_out), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_rst_tx", 32'(tx), 1);
        check_eq("post_rst_busy", 32'(tx_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
